// File: rtl/dram_rd_sequencer_pkg.sv
// Shared constants for the capture BRAM read path: FSM encodings and the
// sub-word select width used by the BRAM rd_ws/wr_ws ports.
package dram_rd_sequencer_pkg;

    localparam int WS_W = 5;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

endpackage

// File: rtl/dram_rd_outreg.sv
// Output sample register with valid/ready handshake; accepts a new sample
// whenever the register is empty or its current sample is being taken.
module dram_rd_outreg #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] din_i,
    output logic              load_o,
    output logic [DATA_W-1:0] dout_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] dout_q;
    logic              valid_q;

    assign load_o  = en_i & (~valid_q | ready_i);
    assign dout_o  = dout_q;
    assign valid_o = valid_q;

    // Outside of loading, a handshake empties the register (used while draining).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (load_o) begin
            dout_q  <= din_i;
            valid_q <= 1'b1;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/dram_rd_sequencer.sv
// Read-side sequencer for the capture BRAM: walks words/sub-words from a start
// point and streams one sample per cycle onto a valid/ready output.
module dram_rd_sequencer
    import dram_rd_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH       = 10,
    parameter int RD_DATA_WIDTH    = 8,
    parameter int RD_DATA_PER_ADDR = 4,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                     rd_clk,
    input  logic                     rd_reset_n,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    start_addr,
    input  logic [WS_W-1:0]          start_ws,
    input  logic [CNT_WIDTH-1:0]     num_samples,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_WIDTH-1:0]    ram_rd_addr,
    output logic [WS_W-1:0]          ram_rd_ws,
    output logic                     ram_rd_ce,
    input  logic [RD_DATA_WIDTH-1:0] ram_rd_data,
    output logic [RD_DATA_WIDTH-1:0] dout,
    output logic                     dout_valid,
    input  logic                     dout_ready
);

    localparam logic [WS_W-1:0]       WS_LAST  = WS_W'(RD_DATA_PER_ADDR - 1);
    localparam logic [WS_W-1:0]       WS_ONE   = WS_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WS_W-1:0]       ws_q, ws_d;
    logic [CNT_WIDTH-1:0]  rem_q, rem_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ce;
    logic                  load;

    dram_rd_outreg #(
        .DATA_W (RD_DATA_WIDTH)
    ) u_outreg (
        .clk_i   (rd_clk),
        .rst_ni  (rd_reset_n),
        .en_i    (state_q == ST_STREAM),
        .clr_i   (abort),
        .ready_i (dout_ready),
        .din_i   (ram_rd_data),
        .load_o  (load),
        .dout_o  (dout),
        .valid_o (dout_valid)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ws_d    = ws_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ce      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = start_addr;
                    ws_d    = start_ws;
                    rem_d   = num_samples;
                    busy_d  = 1'b1;
                    state_d = (num_samples == '0) ? ST_DRAIN : ST_FETCH;
                end
            end
            ST_FETCH: begin
                ce      = 1'b1;
                addr_d  = addr_q + ADDR_ONE;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (load) begin
                    rem_d = rem_q - CNT_ONE;
                    // Fetch the next word in the same cycle the last sub-word is taken,
                    // but only if a sample from it will actually be consumed.
                    if (ws_q == WS_LAST) begin
                        ws_d = '0;
                        if (rem_q != CNT_ONE) begin
                            ce     = 1'b1;
                            addr_d = addr_q + ADDR_ONE;
                        end
                    end else begin
                        ws_d = ws_q + WS_ONE;
                    end
                    if (rem_q == CNT_ONE) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!dout_valid || dout_ready) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            addr_d  = addr_q;
            ws_d    = ws_q;
            rem_d   = rem_q;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            ce      = 1'b0;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_reset_n) begin
        if (!rd_reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            ws_q    <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ws_q    <= ws_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign ram_rd_addr = addr_q;
    assign ram_rd_ws   = ws_q;
    assign ram_rd_ce   = ce;

endmodule

// File: tb/tb_dram_rd_sequencer.sv
// Directed bench for dram_rd_sequencer with a 16-word BRAM model whose sample
// at word w, sub-word s holds 8'h20 + 4*w + s.
module tb_dram_rd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  start_addr = '0;
    logic [4:0]  start_ws = '0;
    logic [15:0] num_samples = '0;
    logic        abort = 1'b0;
    logic        busy, done, ram_rd_ce, dout_valid;
    logic [3:0]  ram_rd_addr;
    logic [4:0]  ram_rd_ws;
    logic [7:0]  ram_rd_data, dout;
    logic        dout_ready = 1'b1;

    dram_rd_sequencer #(
        .ADDR_WIDTH       (4),
        .RD_DATA_WIDTH    (8),
        .RD_DATA_PER_ADDR (4),
        .CNT_WIDTH        (16)
    ) dut (
        .rd_clk      (clk),
        .rd_reset_n  (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .start_ws    (start_ws),
        .num_samples (num_samples),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_ws   (ram_rd_ws),
        .ram_rd_ce   (ram_rd_ce),
        .ram_rd_data (ram_rd_data),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [16];
    logic [31:0] word_q = '0;
    initial begin
        for (int w = 0; w < 16; w++)
            for (int s = 0; s < 4; s++)
                mem[w][s*8 +: 8] = 8'(8'h20 + w * 4 + s);
    end
    always @(posedge clk) if (ram_rd_ce) word_q <= mem[ram_rd_addr];
    assign ram_rd_data = word_q[{ram_rd_ws[1:0], 3'b000} +: 8];

    int rmode = 0;
    logic [3:0] pat = 4'b1001;
    initial forever begin
        @(posedge clk);
        #1;
        dout_ready = (rmode == 0) ? 1'b1 : pat[cyc % 4];
    end

    int         ce_addr [$];
    logic [7:0] smp [$];
    int first_ce = -1, first_vld = -1, last_xfer = -1, done_cyc = -1, done_cnt = 0;
    int frz_err = 0, start_cyc = 0;
    logic       prev_stall = 1'b0;
    logic [3:0] prev_addr = '0;
    logic [4:0] prev_ws = '0;

    initial forever begin
        @(negedge clk);
        if (ram_rd_ce) begin
            ce_addr.push_back(int'(ram_rd_addr));
            if (first_ce < 0) first_ce = cyc;
        end
        if (dout_valid && first_vld < 0) first_vld = cyc;
        if (dout_valid && dout_ready) begin
            smp.push_back(dout);
            last_xfer = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_stall && (ram_rd_ws != prev_ws || ram_rd_addr != prev_addr)) frz_err++;
        if (dout_valid && !dout_ready && ram_rd_ce) frz_err++;
        prev_stall = dout_valid && !dout_ready;
        prev_ws    = ram_rd_ws;
        prev_addr  = ram_rd_addr;
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic start_op(input logic [3:0] a, input logic [4:0] w, input logic [15:0] n);
        ce_addr.delete();
        smp.delete();
        first_ce = -1; first_vld = -1; last_xfer = -1; done_cyc = -1;
        done_cnt = 0; frz_err = 0;
        @(posedge clk); #1;
        start = 1'b1; start_addr = a; start_ws = w; num_samples = n;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 200 && done_cnt == 0; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic chk_samples(input string tag, input int n, input logic [7:0] e [8]);
        chk({tag, "_nsmp"}, smp.size(), n);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_s%0d", tag, i), (i < smp.size()) ? 32'(smp[i]) : 32'hDEAD, 32'(e[i]));
    endtask

    task automatic chk_ce(input string tag, input int a0, input int a1);
        chk({tag, "_nce"}, ce_addr.size(), 2);
        chk({tag, "_ce0"}, (ce_addr.size() > 0) ? ce_addr[0] : -1, a0);
        chk({tag, "_ce1"}, (ce_addr.size() > 1) ? ce_addr[1] : -1, a1);
    endtask

    task automatic run_t1(input string tag, input bit full_rate);
        logic [7:0] e1 [8] = '{8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h3A, 8'h3B};
        start_op(4'd5, 5'd0, 16'd8);
        wait_done(tag);
        chk_ce(tag, 5, 6);
        chk_samples(tag, 8, e1);
        chk({tag, "_ce_lat"}, first_ce - start_cyc, 1);
        chk({tag, "_vld_lat"}, first_vld - start_cyc, 3);
        chk({tag, "_done_lat"}, done_cyc - last_xfer, 1);
        if (full_rate) chk({tag, "_thru"}, last_xfer - first_vld, 7);
        else chk({tag, "_frozen"}, frz_err, 0);
    endtask

    initial begin
        logic [7:0] e3 [8] = '{8'h5C, 8'h5D, 8'h5E, 8'h5F, 8'h20, 8'h21, 8'h22, 8'h23};
        logic [7:0] e4 [8] = '{8'h2E, 8'h2F, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ce", ram_rd_ce, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_addr", ram_rd_addr, 0);
        chk("rst_ws", ram_rd_ws, 0);
        chk("rst_dout", dout, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_t1("t1", 1'b1);

        rmode = 1;
        run_t1("t2", 1'b0);
        rmode = 0;

        start_op(4'd15, 5'd0, 16'd8);
        wait_done("t3");
        chk_ce("t3", 15, 0);
        chk_samples("t3", 8, e3);

        start_op(4'd3, 5'd2, 16'd3);
        wait_done("t4");
        chk_ce("t4", 3, 4);
        chk_samples("t4", 3, e4);

        start_op(4'd7, 5'd1, 16'd0);
        wait_done("t5");
        chk("t5_nce", ce_addr.size(), 0);
        chk("t5_novld", first_vld, -1);
        chk("t5_done_lat", done_cyc - start_cyc, 2);

        start_op(4'd5, 5'd0, 16'd8);
        for (int k = 0; k < 20 && first_vld < 0; k++) @(posedge clk);
        chk("t6a_reached_stream", (first_vld >= 0), 1);
        #1; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("t6a_valid", dout_valid, 0);
        chk("t6a_busy", busy, 0);
        chk("t6a_ce", ram_rd_ce, 0);
        repeat (6) @(posedge clk);
        chk("t6a_no_done", done_cnt, 0);

        start_op(4'd5, 5'd0, 16'd8);
        for (int k = 0; k < 20 && first_vld < 0; k++) @(posedge clk);
        chk("t6b_reached_stream", (first_vld >= 0), 1);
        #1; rst_n = 1'b0;
        #1;
        chk("t6b_valid", dout_valid, 0);
        chk("t6b_busy", busy, 0);
        chk("t6b_ce", ram_rd_ce, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        chk("t6b_no_done", done_cnt, 0);

        run_t1("t6c", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
